data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 4: array-access wait cycles per request (1..15).
REQ-002 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the array.
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port mem_read, input, 4: bit3 is the read enable; bits[2:0] select the load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 Port mem_write, input, 3: bit2 is the write enable; bits[1:0] select the store type: 00 SB, 01 SH, 10 SW.
REQ-007 Port address, input, 32: byte address; only bits [log2(DEPTH_WORDS)+1:0] are used, upper bits are ignored.
REQ-008 Port write_data, input, 32: store data; SB uses [7:0], SH uses [15:0].
REQ-009 Port read_data, output, 32: extended load result, registered.
REQ-010 Port busywait, output, 1: stall request to the pipeline registers; 1 means hold.
REQ-011 Port misaligned, output, 1: registered flag for the last completed request.

Function
REQ-012 The memory SHALL be little-endian: byte k of word w is at address 4w+k.
REQ-013 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-014 A request SHALL be present when mem_read[3]=1 or mem_write[2]=1.
REQ-015 In IDLE with a request present, the block SHALL drive busywait=1 combinationally in that same cycle, latch address/write_data/type, load the counter with LATENCY-1, and enter BUSY.
REQ-016 In IDLE with no request present, busywait SHALL be 0 and the state SHALL be held.
REQ-017 In BUSY, busywait SHALL be 1 and the counter SHALL decrement; at counter=0 the access SHALL be performed and the state SHALL go to DONE.
REQ-018 In DONE, busywait SHALL be 0 for exactly one cycle, read_data and misaligned SHALL be valid, and the next state SHALL be IDLE unconditionally.
REQ-019 Each request SHALL keep busywait high for exactly LATENCY+1 consecutive cycles.
REQ-020 Input changes while in BUSY or DONE SHALL be ignored; only the values latched in IDLE are used.
REQ-021 Loads: LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL return the full word.
REQ-022 Stores SHALL modify only the addressed bytes; SH writes bytes addr and addr+1; SW writes the whole word.
REQ-023 A halfword access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL set misaligned=1, SHALL leave the array unmodified, and SHALL drive read_data=0.
REQ-024 Reserved encodings (mem_read[2:0] of 011, 110 or 111; mem_write[1:0] of 11) SHALL be treated as misaligned, with the same response.
REQ-025 If read and write are requested simultaneously, only the write SHALL be performed; read_data SHALL be held and misaligned SHALL reflect the write.
REQ-026 read_data SHALL retain its value across writes and idle cycles until the next read completes.
REQ-027 Back-to-back requests: a request presented in the cycle after DONE SHALL start in IDLE with no extra gap.

Reset
REQ-028 With rst=1 at a clock edge, the state SHALL go to IDLE and the counter, read_data and misaligned SHALL be 0.
REQ-029 busywait SHALL be 0 during any cycle in which rst=1.
REQ-030 Reset SHALL abort an in-flight request: no array write SHALL occur for it.
REQ-031 Array contents SHALL NOT be cleared by reset.

Verification
REQ-032 With LATENCY=4: SW 0xDEADBEEF to address 0x10, then LW from 0x10 -> read_data=0xDEADBEEF, busywait high 5 cycles per request, low in DONE.
REQ-033 Following REQ-032: LB from 0x13 -> 0xFFFFFFDE; LBU from 0x13 -> 0x000000DE; LH from 0x12 -> 0xFFFFDEAD.
REQ-034 SH 0x00001234 to 0x12, then LW from 0x10 -> 0x1234BEEF, misaligned=0.
REQ-035 LW from 0x11 -> misaligned=1, read_data=0; SW to 0x11 -> misaligned=1, a later LW from 0x10 returns unchanged data.
REQ-036 Assert rst on the 2nd BUSY cycle of SW 0x0 to 0x10 -> next cycle state IDLE, busywait=0, read_data=0; LW from 0x10 returns the prior contents.
REQ-037 Read and write requested together (SW 0xA5A5A5A5 and LW, address 0x20) -> word 0x20 = 0xA5A5A5A5, read_data unchanged; inputs toggled during BUSY have no effect.

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory; every access takes LATENCY+1 stalled cycles then one DONE cycle.
// Backpressure: busywait holds the pipeline from request acceptance in IDLE through the last BUSY cycle.
module data_memory #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_read,
    input  logic [2:0]  mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busywait,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = AW + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [BW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    rtype_q, rtype_d;
    logic [1:0]    wtype_q, wtype_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          mis_q, mis_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          req;
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic          acc_done;
    logic          mem_we;

    logic          wr_mis;
    logic [3:0]    wr_be;
    logic [31:0]   wr_word;

    logic          rd_mis;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_val;

    logic          unused_addr;

    assign unused_addr = ^address[31:BW];

    assign req      = mem_read[3] | mem_write[2];
    assign word_idx = addr_q[BW-1:2];
    assign cur_word = mem_q[word_idx];
    assign acc_done = (state_q == S_BUSY) && (cnt_q == 4'd0);

    // A reset landing on the final BUSY cycle must still suppress the array write.
    assign mem_we = acc_done && is_wr_q && !wr_mis && !rst;

    // Store lane steering: replicate narrow data across the word, pick lanes with byte enables.
    always_comb begin
        wr_mis  = 1'b0;
        wr_be   = 4'b0000;
        wr_word = wdata_q;
        case (wtype_q)
            2'b00: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_mis  = addr_q[0];
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                wr_mis = |addr_q[1:0];
                wr_be  = 4'b1111;
            end
            default: wr_mis = 1'b1;
        endcase
    end

    always_comb begin
        rd_mis  = 1'b0;
        ld_val  = 32'h0;
        ld_half = addr_q[1] ? cur_word[31:16] : cur_word[15:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = cur_word[7:0];
            2'd1:    ld_byte = cur_word[15:8];
            2'd2:    ld_byte = cur_word[23:16];
            default: ld_byte = cur_word[31:24];
        endcase
        case (rtype_q)
            3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001: begin
                rd_mis = addr_q[0];
                ld_val = {{16{ld_half[15]}}, ld_half};
            end
            3'b010: begin
                rd_mis = |addr_q[1:0];
                ld_val = cur_word;
            end
            3'b100: ld_val = {24'h0, ld_byte};
            3'b101: begin
                rd_mis = addr_q[0];
                ld_val = {16'h0, ld_half};
            end
            default: rd_mis = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rtype_d   = rtype_q;
        wtype_d   = wtype_q;
        is_wr_d   = is_wr_q;
        rd_data_d = rd_data_q;
        mis_d     = mis_q;
        busywait  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    busywait = 1'b1;
                    addr_d   = address[BW-1:0];
                    wdata_d  = write_data;
                    rtype_d  = mem_read[2:0];
                    wtype_d  = mem_write[1:0];
                    is_wr_d  = mem_write[2];
                    cnt_d    = CNT_INIT;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                busywait = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    // A write wins over a simultaneous read, so load data is left untouched.
                    if (is_wr_q) begin
                        mis_d = wr_mis;
                    end else begin
                        mis_d     = rd_mis;
                        rd_data_d = rd_mis ? 32'h0 : ld_val;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            busywait = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            rtype_q   <= 3'b000;
            wtype_q   <= 2'b00;
            is_wr_q   <= 1'b0;
            rd_data_q <= 32'h0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rtype_q   <= rtype_d;
            wtype_q   <= wtype_d;
            is_wr_q   <= is_wr_d;
            rd_data_q <= rd_data_d;
            mis_q     <= mis_d;
        end
    end

    // Array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    assign read_data  = rd_data_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, reset/collision sequences, then random ops against a byte-array model.
module tb_data_memory;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busywait;
    logic        misaligned;

    data_memory #(.LATENCY(LAT), .DEPTH_WORDS(256)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .busywait(busywait), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [1024];
    logic [31:0] exp_rd;
    bit          rd_known;

    typedef struct {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        bit          chk_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        mem_read = 4'h0; mem_write = 3'h0; address = 32'h0; write_data = 32'h0;
    endtask

    // Present one request in an IDLE cycle, count stalled cycles, sample results in DONE.
    task automatic run_req(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                           input logic [31:0] wd, input bit scramble,
                           output logic [31:0] act_rd, output logic act_mis, output int n_hi);
        @(negedge clk);
        mem_read = rd; mem_write = wr; address = a; write_data = wd;
        #1;
        n_hi = 0;
        while (busywait === 1'b1 && n_hi < 40) begin
            n_hi++;
            @(negedge clk);
            if (scramble) begin
                mem_read = 4'($urandom); mem_write = 3'($urandom);
                address = $urandom; write_data = $urandom;
            end else begin
                idle();
            end
            #1;
        end
        act_rd = read_data;
        act_mis = misaligned;
        idle();
    endtask

    // Reference behaviour from the access rules: byte array, size/alignment arithmetic.
    task automatic model(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                         input logic [31:0] wd, output logic exp_mis);
        int ba, size;
        logic [31:0] v;
        ba = int'(a[9:0]);
        if (wr[2]) begin
            case (wr[1:0])
                2'b00: size = 1;
                2'b01: size = 2;
                2'b10: size = 4;
                default: size = 0;
            endcase
            if (size == 0) exp_mis = 1'b1;
            else exp_mis = (ba % size) != 0;
            if (!exp_mis) for (int k = 0; k < size; k++) ref_mem[ba + k] = wd[8*k +: 8];
            if (exp_mis) rd_known = 1'b0;
        end else begin
            case (rd[2:0])
                3'b000, 3'b100: size = 1;
                3'b001, 3'b101: size = 2;
                3'b010:         size = 4;
                default:        size = 0;
            endcase
            if (size == 0) exp_mis = 1'b1;
            else exp_mis = (ba % size) != 0;
            if (exp_mis) begin
                exp_rd = 32'h0;
            end else begin
                v = 32'h0;
                for (int k = 0; k < size; k++) v = v | (32'(ref_mem[ba + k]) << (8 * k));
                if (!rd[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
                exp_rd = v;
            end
            rd_known = 1'b1;
        end
    endtask

    task automatic do_op(input string name, input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] a, input logic [31:0] wd, input bit scramble);
        logic [31:0] ar;
        logic am, em;
        int n;
        model(rd, wr, a, wd, em);
        run_req(rd, wr, a, wd, scramble, ar, am, n);
        check({name, " busy"}, 32'(n), 32'(LAT + 1));
        check({name, " mis"}, 32'(am), 32'(em));
        if (rd_known) check({name, " rdata"}, ar, exp_rd);
    endtask

    vec_t vecs [19];

    initial begin
        logic [31:0] ar;
        logic am, dummy;
        int n;

        vecs[0]  = '{4'h0, 3'b110, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1};
        vecs[1]  = '{4'hA, 3'b000, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        vecs[2]  = '{4'h8, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b1};
        vecs[3]  = '{4'hC, 3'b000, 32'h13, 32'h0,        32'h000000DE, 1'b0, 1'b1};
        vecs[4]  = '{4'h9, 3'b000, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b1};
        vecs[5]  = '{4'h0, 3'b101, 32'h12, 32'h00001234, 32'hFFFFDEAD, 1'b0, 1'b1};
        vecs[6]  = '{4'hA, 3'b000, 32'h10, 32'h0,        32'h1234BEEF, 1'b0, 1'b1};
        vecs[7]  = '{4'hA, 3'b000, 32'h11, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[8]  = '{4'h0, 3'b110, 32'h11, 32'h11111111, 32'h0,        1'b1, 1'b0};
        vecs[9]  = '{4'hA, 3'b000, 32'h10, 32'h0,        32'h1234BEEF, 1'b0, 1'b1};
        vecs[10] = '{4'hD, 3'b000, 32'h12, 32'h0,        32'h00001234, 1'b0, 1'b1};
        vecs[11] = '{4'h9, 3'b000, 32'h11, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[12] = '{4'hB, 3'b000, 32'h10, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[13] = '{4'h0, 3'b111, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        vecs[14] = '{4'h0, 3'b100, 32'h11, 32'hFFFFFF80, 32'h0,        1'b0, 1'b0};
        vecs[15] = '{4'hA, 3'b000, 32'h10, 32'h0,        32'h123480EF, 1'b0, 1'b1};
        vecs[16] = '{4'h8, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0, 1'b1};
        vecs[17] = '{4'hE, 3'b000, 32'h10, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[18] = '{4'hA, 3'b000, 32'hFFFFFC10, 32'h0,  32'h123480EF, 1'b0, 1'b1};

        // Reset with a request pending: no stall may be raised.
        rst = 1'b1;
        mem_read = 4'hA; mem_write = 3'b110; address = 32'h10; write_data = 32'h0;
        @(negedge clk); #1;
        check("reset busywait", 32'(busywait), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("reset read_data", read_data, 32'h0);
        check("reset misaligned", 32'(misaligned), 32'h0);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 19; i++) begin
            model(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, dummy);
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, 1'b0, ar, am, n);
            check($sformatf("vec%0d busy", i), 32'(n), 32'(LAT + 1));
            check($sformatf("vec%0d mis", i), 32'(am), 32'(vecs[i].exp_mis));
            if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), ar, vecs[i].exp_rd);
        end

        // Reset on the second BUSY cycle of a store aborts it.
        @(negedge clk);
        mem_write = 3'b110; address = 32'h10; write_data = 32'h0;
        #1;
        check("abort accept busywait", 32'(busywait), 32'h1);
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort rst busywait", 32'(busywait), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort after busywait", 32'(busywait), 32'h0);
        check("abort after read_data", read_data, 32'h0);
        check("abort after misaligned", 32'(misaligned), 32'h0);
        run_req(4'hA, 3'b000, 32'h10, 32'h0, 1'b0, ar, am, n);
        check("abort reload busy", 32'(n), 32'(LAT + 1));
        check("abort reload rdata", ar, 32'h123480EF);

        // Simultaneous read and write: only the write happens, inputs scrambled while busy.
        run_req(4'hA, 3'b110, 32'h20, 32'hA5A5A5A5, 1'b1, ar, am, n);
        check("collide busy", 32'(n), 32'(LAT + 1));
        check("collide rdata held", ar, 32'h123480EF);
        check("collide mis", 32'(am), 32'h0);
        run_req(4'hA, 3'b000, 32'h20, 32'h0, 1'b1, ar, am, n);
        check("collide readback", ar, 32'hA5A5A5A5);
        check("collide readback mis", 32'(am), 32'h0);

        // Fill the whole array so every random read hits defined data.
        rd_known = 1'b0;
        for (int w = 0; w < 256; w++) do_op("fill", 4'h0, 3'b110, 32'(w * 4), $urandom, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  rd;
            logic [2:0]  wr;
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 9);
            rd = (kind <= 4 || kind == 9) ? {1'b1, 3'($urandom)} : 4'h0;
            wr = (kind >= 5) ? {1'b1, 2'($urandom)} : 3'h0;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op("rand", rd, wr, a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
